// File: rtl/eth_framer.sv
// rtl/eth_framer.sv - Ethernet II transmit framer: header insertion, zero padding, length limit
module eth_framer #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       ip_valid,
  input  logic       ip_eof,
  input  logic       ip_err,
  output logic       ip_ready,
  output logic [7:0] eth_data_out,
  output logic       tx_valid,
  output logic       tx_eof,
  output logic       tx_err,
  input  logic       tx_ready
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PAD, DROP} state_t;

  // Header bytes in wire order: DST (6), SRC (6), EtherType (2), MSB first.
  localparam logic [111:0] HDR     = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [10:0]  MIN_LEN = 11'(MIN_PAYLOAD);
  localparam logic [10:0]  MAX_LEN = 11'(MAX_PAYLOAD);

  state_t      state_q, state_d;
  logic [3:0]  hdr_cnt, hdr_d;
  logic [10:0] pay_cnt, pay_d;
  logic [10:0] pay_inc;
  logic        load_ok;
  logic        ld, ld_eof, ld_err;
  logic [7:0]  ld_data;

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (idx == 4'(i)) b = HDR[111-8*i -: 8];
    end
    return b;
  endfunction

  assign load_ok = !tx_valid || tx_ready;
  assign pay_inc = pay_cnt + 11'd1;

  // Next-state, counter updates and output-stage load request.
  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_cnt;
    pay_d    = pay_cnt;
    ld       = 1'b0;
    ld_data  = 8'h00;
    ld_eof   = 1'b0;
    ld_err   = 1'b0;
    ip_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // The waiting payload byte stays upstream until the header is out.
        if (ip_valid && load_ok) begin
          ld      = 1'b1;
          ld_data = hdr_byte(4'd0);
          hdr_d   = 4'd1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = hdr_byte(hdr_cnt);
          hdr_d   = hdr_cnt + 4'd1;
          if (hdr_cnt == 4'd13) begin
            pay_d   = 11'd0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        ip_ready = load_ok;
        if (ip_valid && load_ok) begin
          ld      = 1'b1;
          ld_data = data_in;
          pay_d   = pay_inc;
          if (ip_err) begin
            ld_eof  = 1'b1;
            ld_err  = 1'b1;
            state_d = IDLE;
          end else if (ip_eof && pay_inc >= MIN_LEN) begin
            ld_eof  = 1'b1;
            state_d = IDLE;
          end else if (ip_eof) begin
            state_d = PAD;
          end else if (pay_inc == MAX_LEN) begin
            // Oversize: close the frame as bad and swallow the rest upstream.
            ld_eof  = 1'b1;
            ld_err  = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAD: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = 8'h00;
          pay_d   = pay_inc;
          if (pay_inc == MIN_LEN) begin
            ld_eof  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        ip_ready = 1'b1;
        if (ip_valid && (ip_eof || ip_err)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) ip_ready = 1'b0;
  end

  // State, counters and the single output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hdr_cnt      <= 4'd0;
      pay_cnt      <= 11'd0;
      eth_data_out <= 8'h00;
      tx_valid     <= 1'b0;
      tx_eof       <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_cnt <= hdr_d;
      pay_cnt <= pay_d;
      if (ld) begin
        eth_data_out <= ld_data;
        tx_valid     <= 1'b1;
        tx_eof       <= ld_eof;
        tx_err       <= ld_err;
      end else if (load_ok) begin
        tx_valid <= 1'b0;
        tx_eof   <= 1'b0;
        tx_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_framer.sv
// tb/tb_eth_framer.sv - directed self-checking bench for eth_framer
module tb_eth_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       ip_valid = 1'b0;
  logic       ip_eof = 1'b0;
  logic       ip_err = 1'b0;
  logic       ip_ready;
  logic [7:0] eth_data_out;
  logic       tx_valid;
  logic       tx_eof;
  logic       tx_err;
  logic       tx_ready = 1'b1;

  eth_framer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ip_valid(ip_valid),
    .ip_eof(ip_eof), .ip_err(ip_err), .ip_ready(ip_ready),
    .eth_data_out(eth_data_out), .tx_valid(tx_valid), .tx_eof(tx_eof),
    .tx_err(tx_err), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  logic [7:0] pay [1600];
  logic [7:0] hdr_exp [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h08, 8'h00};

  logic [7:0] rx_data [$];
  bit         rx_eof [$];
  bit         rx_err [$];
  int         rx_cyc [$];
  int         eof_cnt = 0;

  bit         stall_q = 1'b0;
  logic [7:0] hold_data;
  logic       hold_eof, hold_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Output monitor: records accepted bytes and checks hold-stability during stalls.
  always @(negedge clk) begin
    #2;
    if (stall_q && !rst) begin
      check("stall valid", {31'd0, tx_valid}, 32'd1);
      check("stall data", {24'd0, eth_data_out}, {24'd0, hold_data});
      check("stall eof", {31'd0, tx_eof}, {31'd0, hold_eof});
      check("stall err", {31'd0, tx_err}, {31'd0, hold_err});
    end
    stall_q   = tx_valid && !tx_ready;
    hold_data = eth_data_out;
    hold_eof  = tx_eof;
    hold_err  = tx_err;
    if (tx_valid && tx_ready && !rst) begin
      rx_data.push_back(eth_data_out);
      rx_eof.push_back(tx_eof);
      rx_err.push_back(tx_err);
      rx_cyc.push_back(cyc);
      if (tx_eof) eof_cnt++;
    end
  end

  bit timed_out;

  task automatic send_byte(input logic [7:0] b, input logic eof, input logic err);
    int n;
    n = 0;
    data_in  = b;
    ip_eof   = eof;
    ip_err   = err;
    ip_valid = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (ip_ready) break;
      n++;
      if (n > 5000) begin
        timed_out = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int len, input int err_at, input string tag);
    logic [7:0] exp [$];
    bit   exp_bad;
    int   n_send, n_pay, nbad, errs_seen, k, c0;
    @(posedge clk);
    #1;
    rx_data.delete(); rx_eof.delete(); rx_err.delete(); rx_cyc.delete();
    eof_cnt   = 0;
    timed_out = 1'b0;
    exp.delete();
    for (int i = 0; i < 14; i++) exp.push_back(hdr_exp[i]);
    n_pay   = (err_at > 0) ? err_at : ((len > 1500) ? 1500 : len);
    exp_bad = (err_at > 0) || (len > 1500);
    for (int i = 0; i < n_pay; i++) exp.push_back(pay[i]);
    if (err_at == 0) while (exp.size() < 60) exp.push_back(8'h00);
    n_send = (err_at > 0) ? err_at : len;
    c0 = cyc;
    for (int i = 0; i < n_send && !timed_out; i++)
      send_byte(pay[i], 1'(i == len - 1), 1'(i == err_at - 1));
    ip_valid = 1'b0;
    ip_eof   = 1'b0;
    ip_err   = 1'b0;
    check({tag, " ip_ready wait"}, {31'd0, timed_out}, 32'd0);
    k = 0;
    while (eof_cnt == 0 && k < 4000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, " length"}, rx_data.size(), exp.size());
    check({tag, " eof count"}, eof_cnt, 1);
    nbad = 0;
    errs_seen = 0;
    for (int i = 0; i < rx_data.size() && i < exp.size(); i++) begin
      if (rx_data[i] !== exp[i]) nbad++;
      if (rx_err[i]) errs_seen++;
    end
    check({tag, " bad bytes"}, nbad, 0);
    check({tag, " err count"}, errs_seen, exp_bad ? 1 : 0);
    if (rx_data.size() > 0) begin
      check({tag, " last eof"}, {31'd0, rx_eof[rx_data.size()-1]}, 32'd1);
      check({tag, " last err"}, {31'd0, rx_err[rx_data.size()-1]}, {31'd0, exp_bad});
      if (!rnd_ready) begin
        check({tag, " first byte cycle"}, rx_cyc[0] - c0, 1);
        check({tag, " no bubbles"}, rx_cyc[rx_data.size()-1] - rx_cyc[0], rx_data.size() - 1);
        if (rx_data.size() > 14) check({tag, " payload cycle"}, rx_cyc[14] - c0, 15);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1600; i++) pay[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset tx_eof", {31'd0, tx_eof}, 32'd0);
    check("reset tx_err", {31'd0, tx_err}, 32'd0);
    check("reset data", {24'd0, eth_data_out}, 32'd0);
    check("reset ip_ready", {31'd0, ip_ready}, 32'd0);
    rst = 1'b0;

    run_frame(55, 0, "p55");
    run_frame(18, 0, "p18");
    run_frame(46, 0, "p46");
    rnd_ready = 1'b1;
    run_frame(55, 0, "p55 rand ready");
    rnd_ready = 1'b0;
    run_frame(32, 20, "abort");
    run_frame(55, 0, "after abort");
    run_frame(1600, 0, "oversize");
    run_frame(55, 0, "after oversize");

    @(posedge clk);
    #1;
    data_in  = pay[0];
    ip_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("pre-rst valid", {31'd0, tx_valid}, 32'd1);
    check("pre-rst byte5", {24'd0, eth_data_out}, 32'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ip_valid = 1'b0;
    check("post-rst valid", {31'd0, tx_valid}, 32'd0);
    check("post-rst eof", {31'd0, tx_eof}, 32'd0);
    check("post-rst ip_ready", {31'd0, ip_ready}, 32'd0);
    run_frame(55, 0, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_framer.md
# eth_framer

Transmit-side Ethernet II framer: the outbound counterpart of `eth_parser`. It accepts a payload byte stream from the IP layer and emits a complete frame body to the MAC TX path: destination MAC, source MAC and EtherType, then the payload, zero-padded to the minimum payload length. It also enforces the maximum payload length and propagates upstream aborts. CRC/FCS, preamble and inter-frame gap are handled downstream.

## Interface
Parameters:
- `DST_MAC`, 48'hFFFF_FFFF_FFFF: destination MAC, sent MSB byte first.
- `SRC_MAC`, 48'h02_00_00_00_00_01: source MAC, sent MSB byte first.
- `ETHERTYPE`, 16'h0800: sent high byte first.
- `MIN_PAYLOAD`, 46: minimum payload bytes; shorter payloads are zero-padded.
- `MAX_PAYLOAD`, 1500: maximum payload bytes; must be ≥ `MIN_PAYLOAD`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  8 (`byte_t`)  payload byte from the IP layer.
- `ip_valid`  in  1  `data_in` valid.
- `ip_eof`  in  1  last payload byte; qualified by a handshake.
- `ip_err`  in  1  upstream abort, marks the last byte; qualified by a handshake.
- `ip_ready`  out  1  framer accepts the byte this cycle.
- `eth_data_out`  out  8 (`byte_t`)  frame byte to the MAC TX.
- `tx_valid`  out  1  `eth_data_out` valid.
- `tx_eof`  out  1  last byte of the frame.
- `tx_err`  out  1  frame is bad; only asserted together with `tx_eof`.
- `tx_ready`  in  1  downstream accepts the byte.

## Operation
- Handshakes:
  - Upstream transfer: `ip_valid && ip_ready`.
  - Downstream transfer: `tx_valid && tx_ready`.
  - `ip_eof` and `ip_err` are ignored unless a transfer happens.
- Output register:
  - A single stage holds `eth_data_out`, `tx_valid`, `tx_eof` and `tx_err`.
  - It loads when `!tx_valid || tx_ready`; call this `load_ok`.
  - While `tx_valid && !tx_ready`, all four outputs stay stable.
- FSM states: IDLE, HEADER, PAYLOAD, PAD, DROP.
  - IDLE:
    - `ip_ready`=0.
    - When `ip_valid && load_ok`, load `DST_MAC[47:40]`, set `hdr_cnt`=1, and go to HEADER.
    - The payload byte is not consumed in this cycle.
  - HEADER:
    - `ip_ready`=0.
    - On each `load_ok`, load header byte `hdr_cnt` and increment it.
    - Byte order: bytes 0–5 are `DST_MAC`, 6–11 are `SRC_MAC`, 12–13 are `ETHERTYPE`.
    - After byte 13 is loaded, go to PAYLOAD with `pay_cnt`=0.
  - PAYLOAD:
    - `ip_ready = load_ok`.
    - On each upstream transfer, load `data_in` and increment `pay_cnt` (11 bits, counts the byte just accepted).
    - If `ip_err`: load with `tx_eof`=1 and `tx_err`=1, no padding, go to IDLE.
    - Else if `ip_eof` and `pay_cnt+1 ≥ MIN_PAYLOAD`: load with `tx_eof`=1, go to IDLE.
    - Else if `ip_eof`: go to PAD.
    - Else if `pay_cnt+1 == MAX_PAYLOAD`: load with `tx_eof`=1 and `tx_err`=1, go to DROP.
    - `ip_err` takes priority over `ip_eof`, and both take priority over the max-length check.
  - PAD:
    - `ip_ready`=0.
    - On each `load_ok`, load 8'h00 and increment `pay_cnt`.
    - The byte that makes `pay_cnt == MIN_PAYLOAD` carries `tx_eof`=1; then go to IDLE.
  - DROP:
    - `ip_ready`=1, and `tx_valid` is never loaded.
    - Incoming bytes are discarded.
    - Leave for IDLE on the transfer carrying `ip_eof` or `ip_err`.
- Reset:
  - Outputs go to 0: `eth_data_out`=0, `tx_valid`=0, `tx_eof`=0, `tx_err`=0, `ip_ready`=0.
  - State goes to IDLE; `hdr_cnt` and `pay_cnt` go to 0.
  - A reset mid-frame abandons the frame immediately; no `tx_eof` is emitted for it.

## Timing
- Start of frame: `ip_valid` rising at cycle 0 in IDLE gives the first header byte with `tx_valid` at cycle 1.
- With `tx_ready`=1 and `ip_valid` held, the first payload byte appears at cycle 15.
- Pass-through latency: a byte accepted at cycle N appears on `eth_data_out` at N+1.
- `tx_valid` has no bubbles inside the header or pad. Inside the payload, bubbles appear only when `ip_valid` is low.
- Frame length: 14 + max(payload, `MIN_PAYLOAD`) bytes, i.e. 60 to 1514 with default parameters.
- Back-to-back frames:
  - The next frame's header may load in the cycle after the previous frame's final byte loads.
  - No idle cycle is inserted.
  - Minimum gap between `tx_eof` and the next frame's header byte 0 is 0 cycles.
- `ip_ready` is combinational from `tx_ready` and `tx_valid`; there is no combinational path from `ip_valid` to `ip_ready`.

## Test plan
- 55-byte random payload, `tx_ready`=1 → 69 bytes out:
  - Bytes 0–5 are FF; bytes 6–11 are 02 00 00 00 00 01; bytes 12–13 are 08 00.
  - The payload matches in order; `tx_eof` on byte 69 only; `tx_err`=0.
- Payload lengths 18 and 46:
  - 18 bytes → 18 bytes of data plus 28 bytes of 00, total 60 bytes, `tx_eof` on byte 60.
  - 46 bytes → 60 bytes with no pad.
- Same 55-byte frame with `tx_ready` random at 50% → byte sequence identical to the first test. `eth_data_out`, `tx_eof` and `tx_err` stay stable whenever `tx_valid && !tx_ready`.
- 32-byte payload with `ip_err` on byte 20 → 34 bytes out; byte 34 has `tx_eof`=1 and `tx_err`=1; no pad. The following valid 55-byte frame is correct.
- 1600-byte payload:
  - Output is 1514 bytes; byte 1514 has `tx_eof`=1 and `tx_err`=1.
  - The remaining 100 bytes are consumed with `ip_ready`=1 and `tx_valid`=0.
  - The next frame is correct.
- `rst` pulsed for 1 cycle during header byte 5 → `tx_valid`=0 from the next cycle. The next frame restarts at header byte 0 (FF) and is received completely and correctly.
